// File: rtl/div_dispatch.sv
// Front-end between execute and a multi-cycle divider for DIV/DIVU/REM/REMU.
// Short-cuts RISC-V divide corner cases and reuses the last quotient/remainder pair.
module div_dispatch #(
    parameter bit CACHE_EN  = 1'b1,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o,
    output logic        ack_o,
    output logic        div_stb_o,
    output logic        div_cyc_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    output logic        div_signed_o,
    input  logic [31:0] div_quot_i,
    input  logic [31:0] div_rem_i,
    input  logic        div_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic        div_stb_q, div_stb_d;
    logic [31:0] result_q, result_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        sel_rem_q, sel_rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;

    logic        c_valid_q, c_valid_d;
    logic [31:0] c_rs1_q, c_rs1_d;
    logic [31:0] c_rs2_q, c_rs2_d;
    logic        c_signed_q, c_signed_d;
    logic [31:0] c_quot_q, c_quot_d;
    logic [31:0] c_rem_q, c_rem_d;

    logic req_signed;
    logic byp_zero;
    logic byp_ovf;
    logic cache_hit;

    assign req_signed = ~op_i[0];
    assign byp_zero   = BYPASS_EN && (rs2_i == 32'h0000_0000);
    assign byp_ovf    = BYPASS_EN && req_signed && (rs1_i == 32'h8000_0000)
                        && (rs2_i == 32'hFFFF_FFFF);
    assign cache_hit  = CACHE_EN && c_valid_q && (c_rs1_q == rs1_i)
                        && (c_rs2_q == rs2_i) && (c_signed_q == req_signed);

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        div_stb_d  = div_stb_q;
        result_d   = result_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        sel_rem_d  = sel_rem_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        c_valid_d  = c_valid_q;
        c_rs1_d    = c_rs1_q;
        c_rs2_d    = c_rs2_q;
        c_signed_d = c_signed_q;
        c_quot_d   = c_quot_q;
        c_rem_d    = c_rem_q;

        unique case (state_q)
            IDLE: begin
                if (ack_q) begin
                    ack_d = stb_i;
                end else if (stb_i && cyc_i) begin
                    dividend_d = rs1_i;
                    divisor_d  = rs2_i;
                    signed_d   = req_signed;
                    sel_rem_d  = op_i[1];
                    state_d    = DONE;
                    if (byp_zero) begin
                        quot_d = 32'hFFFF_FFFF;
                        rem_d  = rs1_i;
                    end else if (byp_ovf) begin
                        quot_d = 32'h8000_0000;
                        rem_d  = 32'h0000_0000;
                    end else if (cache_hit) begin
                        quot_d = c_quot_q;
                        rem_d  = c_rem_q;
                    end else begin
                        state_d   = BUSY;
                        div_stb_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (div_ack_i) begin
                    quot_d    = div_quot_i;
                    rem_d     = div_rem_i;
                    div_stb_d = 1'b0;
                    state_d   = DONE;
                    if (CACHE_EN) begin
                        c_valid_d  = 1'b1;
                        c_rs1_d    = dividend_q;
                        c_rs2_d    = divisor_q;
                        c_signed_d = signed_q;
                        c_quot_d   = div_quot_i;
                        c_rem_d    = div_rem_i;
                    end
                end
            end
            DONE: begin
                result_d = sel_rem_q ? rem_q : quot_q;
                // An abandoned request (stb_i dropped) completes silently.
                ack_d    = stb_i;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            div_stb_q  <= 1'b0;
            result_q   <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            sel_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            // NOTE: only c_valid_q must reset; the cache data is cleared too for deterministic X-free outputs.
            c_valid_q  <= 1'b0;
            c_rs1_q    <= '0;
            c_rs2_q    <= '0;
            c_signed_q <= 1'b0;
            c_quot_q   <= '0;
            c_rem_q    <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            div_stb_q  <= div_stb_d;
            result_q   <= result_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            sel_rem_q  <= sel_rem_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            c_valid_q  <= c_valid_d;
            c_rs1_q    <= c_rs1_d;
            c_rs2_q    <= c_rs2_d;
            c_signed_q <= c_signed_d;
            c_quot_q   <= c_quot_d;
            c_rem_q    <= c_rem_d;
        end
    end

    assign result_o       = result_q;
    assign ack_o          = ack_q & stb_i;
    assign div_stb_o      = div_stb_q;
    assign div_cyc_o      = div_stb_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_signed_o   = signed_q;

endmodule

// File: tb/tb_div_dispatch.sv
// Scoreboard bench for div_dispatch: two instances (bypass on / bypass off) each with a
// behavioural fixed-latency divider; expected results are hand-computed constants.
module tb_div_dispatch;

    localparam int DIV_LAT = 3;

    typedef struct {
        string       tag;
        int          d;
        logic [31:0] res;
        int          lat;
        int          t0;
        int          tx0;
        int          tx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  stb;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] result   [2];
    logic [1:0]  ack;
    logic [1:0]  div_stb;
    logic [1:0]  div_cyc;
    logic [31:0] div_a    [2];
    logic [31:0] div_b    [2];
    logic [1:0]  div_sgn;
    logic [31:0] div_q    [2];
    logic [31:0] div_r    [2];
    logic [1:0]  div_ack;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc_cnt  = 0;
    int   ntx      [2];
    int   dcnt     [2];
    logic [1:0] stb_prev;
    logic [1:0] ack_prev;
    exp_t sb[$];

    div_dispatch u_dut_byp (
        .clk_i(clk), .rst_n_i(rst_n), .stb_i(stb[0]), .cyc_i(stb[0]), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .result_o(result[0]), .ack_o(ack[0]),
        .div_stb_o(div_stb[0]), .div_cyc_o(div_cyc[0]), .div_dividend_o(div_a[0]),
        .div_divisor_o(div_b[0]), .div_signed_o(div_sgn[0]), .div_quot_i(div_q[0]),
        .div_rem_i(div_r[0]), .div_ack_i(div_ack[0])
    );

    div_dispatch #(.CACHE_EN(1'b1), .BYPASS_EN(1'b0)) u_dut_nobyp (
        .clk_i(clk), .rst_n_i(rst_n), .stb_i(stb[1]), .cyc_i(stb[1]), .op_i(op),
        .rs1_i(rs1), .rs2_i(rs2), .result_o(result[1]), .ack_o(ack[1]),
        .div_stb_o(div_stb[1]), .div_cyc_o(div_cyc[1]), .div_dividend_o(div_a[1]),
        .div_divisor_o(div_b[1]), .div_signed_o(div_sgn[1]), .div_quot_i(div_q[1]),
        .div_rem_i(div_r[1]), .div_ack_i(div_ack[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V divide semantics, standing in for the external divider.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        if (sgn) return {32'(sa / sb_), 32'(sa % sb_)};
        return {a / b, a % b};
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                div_ack[d]  <= 1'b0;
                dcnt[d]     <= 0;
                stb_prev[d] <= 1'b0;
            end else begin
                stb_prev[d] <= div_stb[d];
                if (div_stb[d] && !stb_prev[d]) ntx[d] <= ntx[d] + 1;
                if (div_stb[d] && !div_ack[d]) begin
                    dcnt[d] <= dcnt[d] + 1;
                    if (dcnt[d] + 1 == DIV_LAT) begin
                        div_ack[d] <= 1'b1;
                        {div_q[d], div_r[d]} <= ref_div(div_a[d], div_b[d], div_sgn[d]);
                    end
                end else if (!div_stb[d]) begin
                    div_ack[d] <= 1'b0;
                    dcnt[d]    <= 0;
                end
            end
        end
    end

    // Monitor: one scoreboard pop per rising ack_o.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] && !ack_prev[d]) begin
                if (sb.size() == 0) begin
                    check($sformatf("unexpected_ack_dut%0d", d), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.tag, ".dut"}, d, e.d);
                    check({e.tag, ".result"}, result[d], e.res);
                    check({e.tag, ".latency"}, cyc_cnt - e.t0, e.lat);
                    check({e.tag, ".div_tx"}, ntx[d] - e.tx0, e.tx);
                end
            end
            ack_prev[d] <= ack[d];
        end
    end

    task automatic req(input string tag, input int d, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input int exp_tx);
        exp_t e;
        bit   got;
        @(posedge clk);
        #1;
        op  = o;
        rs1 = a;
        rs2 = b;
        e.tag = tag; e.d = d; e.res = exp_res; e.lat = exp_lat;
        e.t0 = cyc_cnt; e.tx0 = ntx[d]; e.tx = exp_tx;
        sb.push_back(e);
        stb[d] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ack[d];
        end
        if (!got) check({tag, ".ack_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        stb[d] = 1'b0;
    endtask

    task automatic wait_div_stb(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = div_stb[0];
        end
        check({tag, ".div_stb_seen"}, seen, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        stb   = '0;
        op    = '0;
        rs1   = '0;
        rs2   = '0;
        ntx   = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        check("reset.result", result[0], 32'h0);
        check("reset.ack", ack[0], 32'h0);
        check("reset.div_stb", div_stb[0], 32'h0);
        check("reset.dividend", div_a[0], 32'h0);
        check("reset.divisor", div_b[0], 32'h0);
        check("reset.nobyp_div_stb", div_stb[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
        req("t1_divu",   0, 2'b01, 32'd100, 32'd7, 32'd14, DIV_LAT + 2, 1);
        req("t1_remu",   0, 2'b11, 32'd100, 32'd7, 32'd2, 2, 0);
        req("t2_div",    0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT + 2, 1);
        req("t2_rem",    0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 2, 0);
        req("t3_div0",   0, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 0);
        req("t3_remu0",  0, 2'b11, 32'd5, 32'd0, 32'd5, 2, 0);
        req("t4_ovf",    0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
        req("t4_ovfrem", 0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 0);
        req("t4nb_ovf",  1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT + 2, 1);
        req("t4nb_rem",  1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 0);
        req("t4nb_div0", 1, 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, DIV_LAT + 2, 1);
        req("t5_divu",   0, 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, DIV_LAT + 2, 1);
        req("t5_div",    0, 2'b00, 32'hFFFF_FFFF, 32'd3, 32'h0, DIV_LAT + 2, 1);

        // Abandon mid-BUSY: no ack, but the result still lands in the cache.
        @(posedge clk);
        #1;
        op = 2'b01; rs1 = 32'd1000; rs2 = 32'd10;
        stb[0] = 1'b1;
        wait_div_stb("t6_abandon");
        @(posedge clk);
        #1;
        stb[0] = 1'b0;
        repeat (DIV_LAT + 6) @(posedge clk);
        check("t6_abandon.div_stb_idle", div_stb[0], 32'h0);
        req("t6_hit", 0, 2'b11, 32'd1000, 32'd10, 32'd0, 2, 0);

        // Reset mid-BUSY: divider request withdrawn and the cache forgotten.
        @(posedge clk);
        #1;
        op = 2'b01; rs1 = 32'd500; rs2 = 32'd7;
        stb[0] = 1'b1;
        wait_div_stb("t6_rst");
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        stb[0] = 1'b0;
        #1;
        check("t6_rst.div_stb", div_stb[0], 32'h0);
        check("t6_rst.ack", ack[0], 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req("t6_miss", 0, 2'b11, 32'd1000, 32'd10, 32'd0, DIV_LAT + 2, 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
